// File: rtl/exe_stage_unit_if.sv
// Execute-stage bundle: decoded instruction fields in, EX/MEM register fields out.
// The driving stage uses the master modport; the execute stage uses slave.
interface exe_stage_unit_if #(
  parameter int DATA_W = 32
);
  logic              freeze;
  logic              flush;
  logic              valid_in;
  logic [3:0]        exe_cmd;
  logic              s_in;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] val_rm_in;
  logic [3:0]        dest_in;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;

  logic [DATA_W-1:0] alu_res_out;
  logic [DATA_W-1:0] val_rm_out;
  logic [3:0]        dest_out;
  logic              wb_en_out;
  logic              mem_r_en_out;
  logic              mem_w_en_out;
  logic              valid_out;
  logic [3:0]        status_out;

  modport master (
    output freeze, flush, valid_in, exe_cmd, s_in, val1, val2, val_rm_in,
           dest_in, wb_en_in, mem_r_en_in, mem_w_en_in,
    input  alu_res_out, val_rm_out, dest_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, valid_out, status_out
  );

  modport slave (
    input  freeze, flush, valid_in, exe_cmd, s_in, val1, val2, val_rm_in,
           dest_in, wb_en_in, mem_r_en_in, mem_w_en_in,
    output alu_res_out, val_rm_out, dest_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, valid_out, status_out
  );
endinterface

// File: rtl/exe_stage_unit.sv
// ARM execute stage: ALU, NZCV status register and the EX/MEM pipeline register.
// Supports stall (freeze holds everything) and kill (flush inserts a bubble).
module exe_stage_unit #(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  exe_stage_unit_if.slave  bus
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] res_q, rm_q;
  logic [3:0]        dest_q, status_q;
  logic              wb_q, mem_r_q, mem_w_q, valid_q;

  logic [DATA_W-1:0] res;
  logic [DATA_W:0]   sum;
  logic              c_cur, v_cur, c_new, v_new, n_new, z_new;
  logic              flag_write;

  assign c_cur = status_q[1];
  assign v_cur = status_q[0];

  always_comb begin
    res        = '0;
    sum        = '0;
    c_new      = c_cur;
    v_new      = v_cur;
    flag_write = 1'b1;
    case (bus.exe_cmd)
      CMD_MOV: res = bus.val2;
      CMD_MVN: res = ~bus.val2;
      CMD_AND: res = bus.val1 & bus.val2;
      CMD_ORR: res = bus.val1 | bus.val2;
      CMD_EOR: res = bus.val1 ^ bus.val2;
      CMD_ADD, CMD_ADC: begin
        sum   = {1'b0, bus.val1} + {1'b0, bus.val2}
              + {{DATA_W{1'b0}}, (bus.exe_cmd == CMD_ADC) & c_cur};
        res   = sum[DATA_W-1:0];
        c_new = sum[DATA_W];
        v_new = (bus.val1[MSB] == bus.val2[MSB]) && (res[MSB] != bus.val1[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        // Bit DATA_W of the 33-bit difference is the borrow; ARM carry is its inverse.
        sum   = {1'b0, bus.val1} - {1'b0, bus.val2}
              - {{DATA_W{1'b0}}, (bus.exe_cmd == CMD_SBC) & ~c_cur};
        res   = sum[DATA_W-1:0];
        c_new = ~sum[DATA_W];
        v_new = (bus.val1[MSB] != bus.val2[MSB]) && (res[MSB] != bus.val1[MSB]);
      end
      default: flag_write = 1'b0;
    endcase
    n_new = res[MSB];
    z_new = (res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      rm_q     <= '0;
      dest_q   <= '0;
      wb_q     <= 1'b0;
      mem_r_q  <= 1'b0;
      mem_w_q  <= 1'b0;
      valid_q  <= 1'b0;
      status_q <= '0;
    end else if (!bus.freeze) begin
      if (bus.flush || !bus.valid_in) begin
        res_q   <= '0;
        rm_q    <= '0;
        dest_q  <= '0;
        wb_q    <= 1'b0;
        mem_r_q <= 1'b0;
        mem_w_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        res_q   <= res;
        rm_q    <= bus.val_rm_in;
        dest_q  <= bus.dest_in;
        wb_q    <= bus.wb_en_in;
        mem_r_q <= bus.mem_r_en_in;
        mem_w_q <= bus.mem_w_en_in;
        valid_q <= 1'b1;
        if (bus.s_in && flag_write)
          status_q <= {n_new, z_new, c_new, v_new};
      end
    end
  end

  assign bus.alu_res_out  = res_q;
  assign bus.val_rm_out   = rm_q;
  assign bus.dest_out     = dest_q;
  assign bus.wb_en_out    = wb_q;
  assign bus.mem_r_en_out = mem_r_q;
  assign bus.mem_w_en_out = mem_w_q;
  assign bus.valid_out    = valid_q;
  assign bus.status_out   = status_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed bench for exe_stage_unit: ALU results, NZCV updates, freeze/flush and reset.
// Observed state is packed as {valid, wb, mem_r, mem_w, dest, res, rm, nzcv}.
module tb_exe_stage_unit;

  localparam logic [3:0] MOV = 4'b0001, ADD = 4'b0010, ADC = 4'b0011, SUB = 4'b0100,
                         SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111, EOR = 4'b1000,
                         MVN = 4'b1001;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  logic [75:0] obs;
  logic [75:0] exp_v;

  exe_stage_unit_if #(.DATA_W(32)) bus ();

  exe_stage_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [75:0] snap();
    return {bus.valid_out, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out,
            bus.dest_out, bus.alu_res_out, bus.val_rm_out, bus.status_out};
  endfunction

  task automatic applyStimulus(input logic [3:0] cmd, input logic s,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] rm, input logic [3:0] dest,
                               input logic [2:0] ctl, input logic vld);
    bus.exe_cmd     = cmd;
    bus.s_in        = s;
    bus.val1        = a;
    bus.val2        = b;
    bus.val_rm_in   = rm;
    bus.dest_in     = dest;
    bus.wb_en_in    = ctl[2];
    bus.mem_r_en_in = ctl[1];
    bus.mem_w_en_in = ctl[0];
    bus.valid_in    = vld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    applyStimulus(ADD, 1'b1, 32'h11, 32'h22, 32'h33, 4'd5, 3'b111, 1'b1);
    #2 rst = 1'b1;
    #1;
    obs = snap(); n_compared++;
    if (obs !== 76'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_async: got %h expected %h", obs, 76'h0);
    end
    tick();
    obs = snap(); n_compared++;
    if (obs !== 76'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_held: got %h expected %h", obs, 76'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    applyStimulus(ADD, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h1234, 4'd1, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd1, 32'h80000000, 32'h1234, 4'b1001};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL add_ovf: got %h expected %h", obs, exp_v); end

    applyStimulus(SUB, 1'b1, 32'd5, 32'd5, 32'h0, 4'd2, 3'b000, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b000, 4'd2, 32'h0, 32'h0, 4'b0110};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL sub_zero: got %h expected %h", obs, exp_v); end

    applyStimulus(ADC, 1'b1, 32'd1, 32'd2, 32'h0, 4'd3, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd3, 32'd4, 32'h0, 4'b0000};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL adc_c1: got %h expected %h", obs, exp_v); end

    applyStimulus(SBC, 1'b1, 32'd5, 32'd2, 32'h0, 4'd4, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd4, 32'd2, 32'h0, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL sbc_c0: got %h expected %h", obs, exp_v); end

    applyStimulus(AND, 1'b1, 32'hF0, 32'h0F, 32'h0, 4'd5, 3'b000, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b000, 4'd5, 32'h0, 32'h0, 4'b0110};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL and_keep_cv: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_no_update();
    applyStimulus(ADD, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd6, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd6, 32'h0, 32'h0, 4'b0110};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL add_s0: got %h expected %h", obs, exp_v); end

    applyStimulus(SUB, 1'b1, 32'd5, 32'd6, 32'h0, 4'd8, 3'b000, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b000, 4'd8, 32'hFFFFFFFF, 32'h0, 4'b1000};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL sub_borrow: got %h expected %h", obs, exp_v); end

    applyStimulus(4'hF, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd6, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd6, 32'h0, 32'h0, 4'b1000};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL bad_cmd: got %h expected %h", obs, exp_v); end

    applyStimulus(SUB, 1'b1, 32'h80000000, 32'h1, 32'h0, 4'd9, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd9, 32'h7FFFFFFF, 32'h0, 4'b0011};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL sub_ovf: got %h expected %h", obs, exp_v); end

    applyStimulus(MVN, 1'b1, 32'h0, 32'h0, 32'h0, 4'd10, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd10, 32'hFFFFFFFF, 32'h0, 4'b1011};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL mvn: got %h expected %h", obs, exp_v); end

    applyStimulus(ADD, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd11, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd11, 32'h0, 32'h0, 4'b0110};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL add_carry: got %h expected %h", obs, exp_v); end

    applyStimulus(ORR, 1'b0, 32'hF0, 32'h0F, 32'h0, 4'd12, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd12, 32'hFF, 32'h0, 4'b0110};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL orr: got %h expected %h", obs, exp_v); end

    applyStimulus(EOR, 1'b1, 32'hFF, 32'h0F, 32'h0, 4'd13, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd13, 32'hF0, 32'h0, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL eor: got %h expected %h", obs, exp_v); end

    applyStimulus(SUB, 1'b1, 32'd5, 32'd6, 32'h77, 4'd14, 3'b111, 1'b0);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b0, 3'b000, 4'd0, 32'h0, 32'h0, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL bubble: got %h expected %h", obs, exp_v); end

    applyStimulus(ADD, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, 4'd9, 3'b110, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b110, 4'd9, 32'h104, 32'hDEADBEEF, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL ldr_addr: got %h expected %h", obs, exp_v); end

    applyStimulus(ADD, 1'b0, 32'h200, 32'h8, 32'hCAFEF00D, 4'd0, 3'b001, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b001, 4'd0, 32'h208, 32'hCAFEF00D, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL str_addr: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_freeze_flush();
    applyStimulus(ADD, 1'b0, 32'd3, 32'd4, 32'h0, 4'd7, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd7, 32'd7, 32'h0, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL pre_freeze: got %h expected %h", obs, exp_v); end

    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(SUB, 1'b1, 32'(i), 32'd9, 32'h5A5A, 4'd2, 3'b011, 1'b1);
      tick(); obs = snap(); n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL freeze_hold%0d: got %h expected %h", i, obs, exp_v); end
    end

    bus.freeze = 1'b0;
    bus.flush  = 1'b1;
    applyStimulus(SUB, 1'b1, 32'd5, 32'd6, 32'h55, 4'd3, 3'b111, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b0, 3'b000, 4'd0, 32'h0, 32'h0, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL flush: got %h expected %h", obs, exp_v); end

    bus.flush = 1'b0;
    applyStimulus(ADD, 1'b1, 32'd1, 32'd1, 32'h0, 4'd1, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd1, 32'd2, 32'h0, 4'b0000};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL post_flush: got %h expected %h", obs, exp_v); end

    bus.freeze = 1'b1;
    bus.flush  = 1'b1;
    applyStimulus(SUB, 1'b1, 32'd5, 32'd6, 32'h55, 4'd3, 3'b111, 1'b1);
    tick(); obs = snap(); n_compared++;
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL freeze_over_flush: got %h expected %h", obs, exp_v); end
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b1;
    #1;
    obs = snap(); n_compared++;
    if (obs !== 76'h0) begin n_mismatched++; $display("[TB] FAIL midcycle_reset: got %h expected %h", obs, 76'h0); end
    applyStimulus(MOV, 1'b0, 32'h0, 32'hABCD, 32'h0, 4'd4, 3'b100, 1'b1);
    #1 rst = 1'b0;
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd4, 32'hABCD, 32'h0, 4'b0000};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL mov_after_reset: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(SUB, 1'b1, 32'd7, 32'd7, 32'h0, 4'd1, 3'b000, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b000, 4'd1, 32'h0, 32'h0, 4'b0110};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL b2b_cmp: got %h expected %h", obs, exp_v); end

    applyStimulus(SBC, 1'b1, 32'd5, 32'd2, 32'h0, 4'd2, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd2, 32'd3, 32'h0, 4'b0010};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL b2b_sbc_c1: got %h expected %h", obs, exp_v); end

    applyStimulus(ADC, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd3, 3'b100, 1'b1);
    tick(); obs = snap(); n_compared++;
    exp_v = {1'b1, 3'b100, 4'd3, 32'h0, 32'h0, 4'b0110};
    if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL b2b_adc_wrap: got %h expected %h", obs, exp_v); end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_arith();
    test_no_update();
    test_freeze_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
